// File: rtl/holiday_lights_pkg.sv
// Shared encodings and constants for the holiday lights chaser.
package holiday_lights_pkg;

    // Pattern mode, matches the raw 2-bit mode input encoding
    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    // Run/pause controller state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Upper bound on LED bank width; sliced down to N_LEDS by users
    localparam int unsigned LED_MAX = 1024;
    localparam logic [LED_MAX-1:0] LED_ZEROS = '0;

endpackage

// File: rtl/lights_btn_cond.sv
// Raw push-button conditioner: 2-FF synchroniser, optional debounce
// (LIGHTS_DEBOUNCE_EN), rising-edge detect to a registered 1-cycle press pulse.
module lights_btn_cond #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic press_q;

`ifdef LIGHTS_DEBOUNCE_EN
    localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic              stable_q;
    logic [DCNT_W-1:0] dcnt_q;

    // Synchronise, then accept a new level only after DEB_CYCLES stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != stable_q) begin
                if (dcnt_q == DCNT_W'(DEB_CYCLES - 1)) begin
                    stable_q <= sync2_q;
                    dcnt_q   <= '0;
                    press_q  <= sync2_q;
                end else begin
                    dcnt_q <= dcnt_q + DCNT_W'(1);
                end
            end else begin
                dcnt_q <= '0;
            end
        end
    end
`else
    // Synchronise; the pulse is the synchroniser output's rising edge, computed
    // one stage early so it is registered without adding latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= sync1_q & ~sync2_q;
        end
    end
`endif

    assign press_o = press_q;

endmodule

// File: rtl/holiday_lights_ctrl.sv
// LED chaser: segment of len_sel+1 LEDs rotated/bounced across N_LEDS, or a
// fill bar, stepped every TICK_DIV cycles; button toggles run/pause.
// Optional button debounce is enabled by defining LIGHTS_DEBOUNCE_EN.
module holiday_lights_ctrl
    import holiday_lights_pkg::*;
#(
    parameter int unsigned N_LEDS     = 16,
    parameter int unsigned LEN_W      = 3,
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    input  logic [LEN_W-1:0]  len_sel,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              running
);

    localparam int unsigned POS_W  = $clog2(N_LEDS);
    localparam int unsigned FILL_W = $clog2(N_LEDS + 1);
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned SEG_W  = LEN_W + 1;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_dn_q, dir_dn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    mode_e              mode_q, mode_d;
    logic [N_LEDS-1:0]  led_q, led_d;
    logic               running_q;

    logic               press;
    logic               tick_c;
    logic [SEG_W-1:0]   seg_len_c;
    logic [POS_W-1:0]   bounce_lim_c;

    lights_btn_cond #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn),
        .press_o (press)
    );

    assign tick_c       = (state_q == ST_RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign seg_len_c    = SEG_W'(len_q) + SEG_W'(1);
    assign bounce_lim_c = POS_W'(N_LEDS - 32'(seg_len_c));

    // Next state: divider, run/pause control, pattern step and config latch
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_dn_d = dir_dn_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        len_d    = len_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (press) begin
                    state_d  = ST_RUN;
                    pos_d    = '0;
                    dir_dn_d = 1'b0;
                    fill_d   = '0;
                    len_d    = len_sel;
                    mode_d   = mode_e'(mode);
                end
            end
            ST_RUN: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    len_d  = len_sel;
                    mode_d = mode_e'(mode);
                    case (mode_q)
                        MODE_ROT_L:
                            pos_d = (pos_q == POS_W'(N_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
                        MODE_ROT_R:
                            pos_d = (pos_q == '0) ? POS_W'(N_LEDS - 1) : pos_q - POS_W'(1);
                        MODE_BOUNCE: begin
                            if (pos_q > bounce_lim_c) begin
                                pos_d    = bounce_lim_c;
                                dir_dn_d = 1'b1;
                            end else if (!dir_dn_q) begin
                                if (pos_q == bounce_lim_c) begin
                                    dir_dn_d = 1'b1;
                                    pos_d    = (bounce_lim_c == '0) ? '0 : pos_q - POS_W'(1);
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    dir_dn_d = 1'b0;
                                    pos_d    = (bounce_lim_c == '0) ? '0 : POS_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                        default:
                            fill_d = (fill_q == FILL_W'(N_LEDS)) ? '0 : fill_q + FILL_W'(1);
                    endcase
                end
                if (press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // LED image of the current position/fill; wrap handled by compare-and-subtract
    always_comb begin
        int unsigned off;
        off   = 0;
        led_d = LED_ZEROS[N_LEDS-1:0];
        if (state_q != ST_IDLE) begin
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                if (mode_q == MODE_FILL) begin
                    led_d[i] = (32'(fill_q) > i);
                end else begin
                    off      = (i >= 32'(pos_q)) ? i - 32'(pos_q) : i + N_LEDS - 32'(pos_q);
                    led_d[i] = (off < 32'(seg_len_c));
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            dir_dn_q  <= 1'b0;
            cnt_q     <= '0;
            fill_q    <= '0;
            len_q     <= '0;
            mode_q    <= MODE_ROT_L;
            led_q     <= LED_ZEROS[N_LEDS-1:0];
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dir_dn_q  <= dir_dn_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign led     = led_q;
    assign running = running_q;

endmodule

// File: tb/tb_holiday_lights_ctrl.sv
// Bench for holiday_lights_ctrl: randomized runs checked every cycle against a
// closed-form pattern model; LIGHTS_DEBOUNCE_EN selects the debounced build.
module tb_holiday_lights_ctrl;

    localparam int unsigned N    = 16;
    localparam int unsigned LW   = 3;
    localparam int unsigned TDIV = 4;
    localparam int unsigned DEB  = 8;
`ifdef LIGHTS_DEBOUNCE_EN
    localparam int OFF     = 3;
    localparam int RUNLEN  = DEB;
    localparam int PRESS_H = 12;
`else
    localparam int OFF     = 2;
    localparam int RUNLEN  = 1;
    localparam int PRESS_H = 3;
`endif
    localparam int NLIT = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn;
    logic [LW-1:0] len_sel;
    logic [1:0]    mode;
    logic [N-1:0]  led;
    logic          running;

    int vectors = 0;
    int fails   = 0;

    bit hist[$];
    int m_st;
    int m_r;
    int m_mode;
    int m_len;
    int m_since;
    int trial;
    logic [N-1:0] m_led;
    logic         m_run;

    int           lit_trial [NLIT] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    int           lit_since [NLIT] = '{1, 5, 57, 61, 65, 65, 69, 73, 1, 5, 9, 53, 57};
    logic [N-1:0] lit_val   [NLIT] = '{16'h0007, 16'h000E, 16'hC001, 16'h8003, 16'h0007,
                                       16'hFFFF, 16'h0000, 16'h0001,
                                       16'h0003, 16'h8001, 16'hC000,
                                       16'hE000, 16'h7000};

    always #5 clk = ~clk;

    holiday_lights_ctrl #(
        .N_LEDS     (N),
        .LEN_W      (LW),
        .TICK_DIV   (TDIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .len_sel (len_sel),
        .mode    (mode),
        .led     (led),
        .running (running)
    );

    // Expected LEDs after k steps from RUN entry, straight from the mode rules
    function automatic logic [N-1:0] pattern(int md, int len, int k);
        logic [N-1:0] p;
        int pos;
        int lim;
        int t;
        p = '0;
        if (md == 3) begin
            for (int i = 0; i < (k % (N + 1)); i++) p[i] = 1'b1;
            return p;
        end
        case (md)
            0: pos = k % N;
            1: pos = (N - (k % N)) % N;
            default: begin
                lim = N - len;
                if (lim == 0) pos = 0;
                else begin
                    t   = k % (2 * lim);
                    pos = (t <= lim) ? t : 2 * lim - t;
                end
            end
        endcase
        for (int j = 0; j < len; j++) p[(pos + j) % N] = 1'b1;
        return p;
    endfunction

    // A press lands on edge e when btn was high for exactly RUNLEN samples ending OFF edges earlier
    function automatic bit press_seen(int e);
        int idx;
        for (int k = 0; k < RUNLEN; k++) begin
            idx = e - OFF - k;
            if (idx < 0) return 1'b0;
            if (!hist[idx]) return 1'b0;
        end
        idx = e - OFF - RUNLEN;
        if (idx >= 0 && hist[idx]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s trial=%0d observed=%h expected=%h", tag, trial, obs, exp);
        end
    endtask

    // One clock: advance the model across the edge, then compare at the falling edge
    task automatic cycle();
        int e;
        bit p;
        @(posedge clk);
        hist.push_back(btn);
        e = hist.size() - 1;
        p = press_seen(e);
        m_led = (m_st == 0) ? '0 : pattern(m_mode, m_len, m_r / TDIV);
        if (m_st != 0) m_since++;
        case (m_st)
            0: if (p) begin
                m_st    = 1;
                m_r     = 0;
                m_since = 0;
                m_mode  = int'(mode);
                m_len   = int'(len_sel) + 1;
            end
            1: begin
                m_r++;
                if (p) m_st = 2;
            end
            default: if (p) m_st = 1;
        endcase
        m_run = (m_st == 1);
        @(negedge clk);
        check("led", led, m_led);
        check("running", N'(running), N'(m_run));
        if (m_st != 0) begin
            for (int i = 0; i < NLIT; i++) begin
                if (lit_trial[i] == trial && lit_since[i] == m_since)
                    check("led_literal", led, lit_val[i]);
            end
        end
    endtask

    task automatic hold_btn(int h);
        btn = 1'b1;
        repeat (h) cycle();
        btn = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = 1'b0;
        mode    = 2'd0;
        len_sel = '0;
        trial   = 0;
        repeat (3) @(negedge clk);
        check("reset_led", led, '0);
        check("reset_running", N'(running), '0);

        for (int t = 0; t < 24; t++) begin
            trial = t;
            if (t > 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_led", led, '0);
                check("async_reset_running", N'(running), '0);
                @(negedge clk);
            end
            case (t)
                0: begin mode = 2'd0; len_sel = 3'd2; end
                1: begin mode = 2'd3; len_sel = 3'd0; end
                2: begin mode = 2'd1; len_sel = 3'd1; end
                3: begin mode = 2'd2; len_sel = 3'd2; end
                default: begin
                    mode    = 2'($urandom_range(0, 3));
                    len_sel = 3'($urandom_range(0, 7));
                end
            endcase
            m_st    = 0;
            m_r     = 0;
            m_since = 0;
            hist.delete();
            rst_n = 1'b1;
            repeat (2) cycle();
            hold_btn(PRESS_H);
            repeat (85) cycle();
            hold_btn(PRESS_H);
            repeat ($urandom_range(40, 60)) cycle();
            hold_btn(PRESS_H);
            repeat ($urandom_range(10, 40)) cycle();
`ifdef LIGHTS_DEBOUNCE_EN
            hold_btn(5);
            repeat (20) cycle();
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
